// File: rtl/bit_serializer_pkg.sv
// Shared FSM encoding and default word width for the bit serializer.
package bit_serializer_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bit_serializer_hold.sv
// One-word input holding register; in_ready depends on registered state only.
module bit_serializer_hold #(
    parameter int WIDTH = bit_serializer_pkg::DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             take,
    output logic             in_ready,
    output logic [WIDTH-1:0] hold,
    output logic             hold_full
);

    logic accept;

    assign in_ready = !hold_full;
    assign accept   = in_valid && in_ready;

    // Accept and take cannot both move hold_full: take only matters when full,
    // and accept only happens when empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (clear) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold      <= in_data;
            hold_full <= 1'b1;
        end else if (take) begin
            hold_full <= 1'b0;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter: holding register feeds a shift register that
// emits one bit per bit_en strobe, with back-to-back words and no bubble.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bit_en,
    input  logic             clear,
    output logic             out_bit,
    output logic             out_valid,
    output logic             last_bit
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t           state, state_n;
    logic [WIDTH-1:0] sreg, sreg_n, hold, shifted;
    logic [CW-1:0]    cnt, cnt_n;
    logic             hold_full, take;

    bit_serializer_hold #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .take      (take),
        .in_ready  (in_ready),
        .hold      (hold),
        .hold_full (hold_full)
    );

    assign shifted   = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    assign out_valid = (state == SHIFT);
    assign out_bit   = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
    assign last_bit  = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_n;
            sreg  <= sreg_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        sreg_n  = sreg;
        cnt_n   = cnt;
        take    = 1'b0;
        if (clear) begin
            state_n = IDLE;
            sreg_n  = '0;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (hold_full) begin
                        sreg_n  = hold;
                        cnt_n   = '0;
                        take    = 1'b1;
                        state_n = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        if (last_bit) begin
                            // Reload from hold on the final bit so a waiting word follows without a gap
                            sreg_n  = hold;
                            cnt_n   = '0;
                            take    = 1'b1;
                            state_n = hold_full ? SHIFT : IDLE;
                        end else begin
                            sreg_n = shifted;
                            cnt_n  = cnt + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first instances share stimulus;
// table vectors, corner sequences and a random run against a bit-queue model.
module tb_bit_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid, bit_en, clear;
    logic       m_ready, m_bit, m_valid, m_last;
    logic       l_ready, l_bit, l_valid, l_last;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(m_ready),
        .bit_en(bit_en), .clear(clear), .out_bit(m_bit), .out_valid(m_valid), .last_bit(m_last)
    );

    bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(l_ready),
        .bit_en(bit_en), .clear(clear), .out_bit(l_bit), .out_valid(l_valid), .last_bit(l_last)
    );

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_msb;  // first emitted bit in [7]
        logic [7:0] exp_lsb;
        logic [7:0] exp_det;  // "10110" detector hits, per bit
        bit         tog;
    } vec_t;

    vec_t tv[6];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one word from idle and capture what both instances emit.
    task automatic run_word(input logic [7:0] d, input bit tog, output int n,
                            output logic [7:0] gm, output logic [7:0] gl,
                            output logic [7:0] lm, output logic [7:0] dm, output int vc);
        logic [4:0] hist;
        int cyc;
        n = 0; vc = 0; cyc = 0; hist = '0;
        gm = '0; gl = '0; lm = '0; dm = '0;
        chk("ready_before_accept", m_ready, 1);
        in_data = d; in_valid = 1'b1; bit_en = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 8'($urandom);
        chk("valid_low_after_accept", m_valid, 0);
        tick();
        chk("valid_high_latency2", m_valid, 1);
        while (n < 8 && cyc < 64) begin
            bit_en = tog ? (cyc % 2 == 1) : 1'b1;
            if (m_valid) vc++;
            if (m_valid && bit_en) begin
                gm = {gm[6:0], m_bit};
                gl = {gl[6:0], l_bit};
                lm = {lm[6:0], m_last};
                dm = {dm[6:0], ({hist[3:0], m_bit} == 5'b10110)};
                hist = {hist[3:0], m_bit};
                n++;
            end
            tick();
            cyc++;
        end
        bit_en = 1'b0;
    endtask

    initial begin
        int n, vc, gaps, rlow, wi;
        logic [7:0] gm, gl, lm, dm;
        logic [15:0] got16;
        bit started, acc;
        bit qm[$], qml[$], ql[$], qll[$];

        tv[0] = '{8'hB0, 8'hB0, 8'h0D, 8'h08, 1'b0};
        tv[1] = '{8'h01, 8'h01, 8'h80, 8'h00, 1'b1};
        tv[2] = '{8'hA5, 8'hA5, 8'hA5, 8'h00, 1'b0};
        tv[3] = '{8'h3C, 8'h3C, 8'h3C, 8'h00, 1'b1};
        tv[4] = '{8'h96, 8'h96, 8'h69, 8'h01, 1'b0};
        tv[5] = '{8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0};

        rst = 1'b0; in_data = '0; in_valid = 1'b0; bit_en = 1'b0; clear = 1'b0;
        repeat (3) tick();
        chk("rst_in_ready", m_ready, 1);
        chk("rst_out_valid", m_valid, 0);
        chk("rst_out_bit", m_bit, 0);
        chk("rst_last_bit", m_last, 0);
        chk("rst_lsb_ready", l_ready, 1);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            run_word(tv[i].data, tv[i].tog, n, gm, gl, lm, dm, vc);
            chk($sformatf("tv%0d_bits_done", i), n, 8);
            chk($sformatf("tv%0d_msb_seq", i), gm, tv[i].exp_msb);
            chk($sformatf("tv%0d_lsb_seq", i), gl, tv[i].exp_lsb);
            chk($sformatf("tv%0d_last_mask", i), lm, 8'h01);
            chk($sformatf("tv%0d_detect", i), dm, tv[i].exp_det);
            chk($sformatf("tv%0d_valid_cycles", i), vc, tv[i].tog ? 16 : 8);
            chk($sformatf("tv%0d_idle_after", i), m_valid, 0);
        end

        // Back-to-back words: no bubble between them.
        in_data = 8'hA5; in_valid = 1'b1; bit_en = 1'b1;
        wi = 0; started = 0; gaps = 0; n = 0; got16 = '0; rlow = 0;
        for (int cyc = 0; cyc < 60 && n < 16; cyc++) begin
            if (m_valid) begin
                started = 1;
                got16 = {got16[14:0], m_bit};
                n++;
            end else if (started) gaps++;
            if (wi == 1 && !m_ready) rlow++;
            acc = in_valid && m_ready;
            tick();
            if (acc) begin
                wi++;
                if (wi < 2) in_data = 8'h3C;
                else in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b_bits", n, 16);
        chk("b2b_seq", got16, 16'hA53C);
        chk("b2b_gaps", gaps, 0);
        chk("b2b_ready_low_cycles", rlow, 1);
        chk("b2b_idle_after", m_valid, 0);

        // Clear at bit 3 while a second word is held.
        in_data = 8'hB0; in_valid = 1'b1; bit_en = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        in_data = 8'h3C; in_valid = 1'b1; bit_en = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("clr_pre_valid", m_valid, 1);
        chk("clr_pre_ready", m_ready, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr_valid", m_valid, 0);
        chk("clr_ready", m_ready, 1);
        chk("clr_last", m_last, 0);
        vc = 0;
        for (int c = 0; c < 20; c++) begin
            if (m_valid || l_valid) vc++;
            tick();
        end
        chk("clr_nothing_emitted", vc, 0);

        // Reset mid-word at bit 5, then a fresh word.
        in_data = 8'hA5; in_valid = 1'b1; bit_en = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (6) tick();
        chk("rst5_pre_valid", m_valid, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst5_async_valid", m_valid, 0);
        chk("rst5_async_ready", m_ready, 1);
        chk("rst5_async_bit", m_bit, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("rst5_idle", m_valid, 0);
        run_word(8'hFF, 1'b0, n, gm, gl, lm, dm, vc);
        chk("rst5_bits", n, 8);
        chk("rst5_ones", gm, 8'hFF);
        chk("rst5_valid_cycles", vc, 8);
        vc = 0;
        bit_en = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (m_valid) vc++;
            tick();
        end
        chk("rst5_no_leftover", vc, 0);

        // Random traffic against a bit-queue model of both orders.
        for (int c = 0; c < 3040; c++) begin
            if (c < 3000) begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = 8'($urandom);
                bit_en   = ($urandom_range(0, 3) != 0);
            end else begin
                in_valid = 1'b0;
                bit_en   = 1'b1;
            end
            if (in_valid && m_ready)
                for (int k = 0; k < 8; k++) begin
                    qm.push_back(in_data[7-k]);
                    qml.push_back(k == 7);
                end
            if (in_valid && l_ready)
                for (int k = 0; k < 8; k++) begin
                    ql.push_back(in_data[k]);
                    qll.push_back(k == 7);
                end
            if (m_valid) begin
                if (qm.size() == 0) chk("rnd_msb_extra_bit", 1, 0);
                else begin
                    chk("rnd_msb_bit", m_bit, qm[0]);
                    chk("rnd_msb_last", m_last, qml[0]);
                    if (bit_en) begin
                        void'(qm.pop_front());
                        void'(qml.pop_front());
                    end
                end
            end
            if (l_valid) begin
                if (ql.size() == 0) chk("rnd_lsb_extra_bit", 1, 0);
                else begin
                    chk("rnd_lsb_bit", l_bit, ql[0]);
                    chk("rnd_lsb_last", l_last, qll[0]);
                    if (bit_en) begin
                        void'(ql.pop_front());
                        void'(qll.pop_front());
                    end
                end
            end
            tick();
        end
        chk("rnd_msb_drained", qm.size(), 0);
        chk("rnd_lsb_drained", ql.size(), 0);
        chk("rnd_idle_end", m_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
